// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI write-channel arbiter.
package axi_arb_pkg;

   // Arbiter FSM: arbitrate, forward AW, forward W beats, forward B.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;

   localparam int unsigned AXI_AW = 32;
   localparam int unsigned AXI_DW = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot winner, search starts at ptr+1.
module rr_pick #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         win
);

   localparam int unsigned IW = $clog2(NREQ);

   logic          found;
   logic [IW-1:0] idx;

   // Walk the requesters from ptr+1 upward (mod NREQ); first set one wins.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = IW'((32'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master (AW/W/B) among NREQ
// requesters; one burst in flight, grant held from AW through B.
module axi_wr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = AXI_AW,
   parameter int unsigned DW   = AXI_DW
) (
   input  logic                     axi_aclk,
   input  logic                     axi_areset,
   // requester AW
   input  logic [NREQ-1:0]          s_awvalid,
   output logic [NREQ-1:0]          s_awready,
   input  logic [NREQ*AW-1:0]       s_awaddr,
   input  logic [NREQ*8-1:0]        s_awlen,
   input  logic [NREQ*3-1:0]        s_awsize,
   input  logic [NREQ*2-1:0]        s_awburst,
   // requester W
   input  logic [NREQ*DW-1:0]       s_wdata,
   input  logic [NREQ*(DW/8)-1:0]   s_wstrb,
   input  logic [NREQ-1:0]          s_wlast,
   input  logic [NREQ-1:0]          s_wvalid,
   output logic [NREQ-1:0]          s_wready,
   // requester B
   output logic [1:0]               s_bresp,
   output logic [NREQ-1:0]          s_bvalid,
   input  logic [NREQ-1:0]          s_bready,
   // master AW
   output logic [AW-1:0]            m_awaddr,
   output logic [7:0]               m_awlen,
   output logic [2:0]               m_awsize,
   output logic [1:0]               m_awburst,
   output logic                     m_awvalid,
   input  logic                     m_awready,
   // master W
   output logic [DW-1:0]            m_wdata,
   output logic [DW/8-1:0]          m_wstrb,
   output logic                     m_wlast,
   output logic                     m_wvalid,
   input  logic                     m_wready,
   // master B
   input  logic [1:0]               m_bresp,
   input  logic                     m_bvalid,
   output logic                     m_bready,
   // status
   output logic [NREQ-1:0]          grant,
   output logic                     wlast_err
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned SW = DW / 8;

   arb_state_t    state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] owner;
   logic [7:0]    beat_cnt;
   logic [NREQ-1:0] pick;
   logic          aw_hs;
   logic          w_hs;
   logic          b_hs;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req (s_awvalid),
      .ptr (rr_ptr),
      .win (pick)
   );

   // Index of the one-hot owner; slice 0 when nothing is granted.
   always_comb begin
      owner = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) owner = IW'(i);
      end
   end

   assign aw_hs = m_awvalid && m_awready;
   assign w_hs  = m_wvalid && m_wready;
   assign b_hs  = m_bvalid && m_bready;

   // Channel muxes: pure combinational steering on registered grant/state.
   always_comb begin
      m_awaddr  = s_awaddr[owner*AW +: AW];
      m_awlen   = s_awlen[owner*8 +: 8];
      m_awsize  = s_awsize[owner*3 +: 3];
      m_awburst = s_awburst[owner*2 +: 2];
      m_awvalid = (state == ADDR) && s_awvalid[owner];
      s_awready = (state == ADDR && m_awready) ? grant : '0;

      m_wdata   = s_wdata[owner*DW +: DW];
      m_wstrb   = s_wstrb[owner*SW +: SW];
      m_wlast   = (beat_cnt == 8'd0);
      m_wvalid  = (state == DATA) && s_wvalid[owner];
      s_wready  = (state == DATA && m_wready) ? grant : '0;

      s_bresp   = m_bresp;
      s_bvalid  = (state == RESP && m_bvalid) ? grant : '0;
      m_bready  = (state == RESP) && s_bready[owner];
   end

   // Arbiter FSM with grant, round-robin pointer, beat counter and error flag.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= IW'(NREQ - 1);
         beat_cnt  <= 8'd0;
         wlast_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|s_awvalid) begin
                  grant <= pick;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (aw_hs) begin
                  beat_cnt <= s_awlen[owner*8 +: 8];
                  state    <= DATA;
               end
            end
            DATA: begin
               if (w_hs) begin
                  // Requester's view of the last beat must match ours.
                  if (s_wlast[owner] != m_wlast) wlast_err <= 1'b1;
                  if (beat_cnt == 8'd0) state <= RESP;
                  else beat_cnt <= beat_cnt - 8'd1;
               end
            end
            RESP: begin
               if (b_hs) begin
                  rr_ptr <= owner;
                  grant  <= '0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter (NREQ=2) with AW/W scoreboards.
module tb_axi_wr_arbiter;
   import axi_arb_pkg::*;

   localparam int NREQ     = 2;
   localparam int AW       = 32;
   localparam int DW       = 64;
   localparam int WAIT_MAX = 2000;

   logic                 clk;
   logic                 axi_areset;
   logic [NREQ-1:0]      s_awvalid, s_awready;
   logic [NREQ*AW-1:0]   s_awaddr;
   logic [NREQ*8-1:0]    s_awlen;
   logic [NREQ*3-1:0]    s_awsize;
   logic [NREQ*2-1:0]    s_awburst;
   logic [NREQ*DW-1:0]   s_wdata;
   logic [NREQ*8-1:0]    s_wstrb;
   logic [NREQ-1:0]      s_wlast, s_wvalid, s_wready;
   logic [1:0]           s_bresp;
   logic [NREQ-1:0]      s_bvalid, s_bready;
   logic [AW-1:0]        m_awaddr;
   logic [7:0]           m_awlen;
   logic [2:0]           m_awsize;
   logic [1:0]           m_awburst;
   logic                 m_awvalid, m_awready;
   logic [DW-1:0]        m_wdata;
   logic [7:0]           m_wstrb;
   logic                 m_wlast, m_wvalid, m_wready;
   logic [1:0]           m_bresp;
   logic                 m_bvalid, m_bready;
   logic [NREQ-1:0]      grant;
   logic                 wlast_err;

   axi_wr_arbiter #(
      .NREQ (NREQ),
      .AW   (AW),
      .DW   (DW)
   ) dut (
      .axi_aclk   (clk),
      .axi_areset (axi_areset),
      .s_awvalid  (s_awvalid),
      .s_awready  (s_awready),
      .s_awaddr   (s_awaddr),
      .s_awlen    (s_awlen),
      .s_awsize   (s_awsize),
      .s_awburst  (s_awburst),
      .s_wdata    (s_wdata),
      .s_wstrb    (s_wstrb),
      .s_wlast    (s_wlast),
      .s_wvalid   (s_wvalid),
      .s_wready   (s_wready),
      .s_bresp    (s_bresp),
      .s_bvalid   (s_bvalid),
      .s_bready   (s_bready),
      .m_awaddr   (m_awaddr),
      .m_awlen    (m_awlen),
      .m_awsize   (m_awsize),
      .m_awburst  (m_awburst),
      .m_awvalid  (m_awvalid),
      .m_awready  (m_awready),
      .m_wdata    (m_wdata),
      .m_wstrb    (m_wstrb),
      .m_wlast    (m_wlast),
      .m_wvalid   (m_wvalid),
      .m_wready   (m_wready),
      .m_bresp    (m_bresp),
      .m_bvalid   (m_bvalid),
      .m_bready   (m_bready),
      .grant      (grant),
      .wlast_err  (wlast_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      int         owner;
      logic [7:0] len;
   } aw_exp_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } w_exp_t;

   aw_exp_t    aw_q[$];
   w_exp_t     w_q[$];
   aw_exp_t    ae;
   w_exp_t     we;
   int         cyc = 0;
   int         raise_cyc [NREQ];
   int         cur_owner = 0;
   int         w_hs_cnt = 0;
   int         s1_wready_cnt = 0;
   bit         chk_lat = 1'b0;
   bit         w_toggle = 1'b0;
   logic [1:0] bresp_cfg = BRESP_OKAY;

   function automatic logic [31:0] addr_of(input int r);
      return 32'h1000_0000 + 32'(r) * 32'h1000;
   endfunction

   function automatic logic [63:0] data_of(input int r, input int id, input int beat);
      return {8'(r), 24'(id), 32'(beat)};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Master-side monitor: compares forwarded AW and W traffic with the scoreboards.
   always @(negedge clk) begin
      if (!axi_areset) begin
         if (s_wready[1]) s1_wready_cnt++;
         if (m_awvalid && m_awready) begin
            check_eq("aw_expected", 64'(aw_q.size() > 0), 64'd1);
            if (aw_q.size() > 0) begin
               ae = aw_q.pop_front();
               check_eq("aw_grant", 64'(grant), 64'(1 << ae.owner));
               check_eq("aw_addr", 64'(m_awaddr), 64'(addr_of(ae.owner)));
               check_eq("aw_len", 64'(m_awlen), 64'(ae.len));
               check_eq("aw_size", 64'(m_awsize), 64'd3);
               check_eq("aw_burst", 64'(m_awburst), 64'd1);
               cur_owner = ae.owner;
               if (chk_lat) check_eq("aw_latency", 64'(cyc - raise_cyc[ae.owner]), 64'd1);
            end
         end
         if (m_wvalid && m_wready) begin
            w_hs_cnt++;
            check_eq("w_expected", 64'(w_q.size() > 0), 64'd1);
            if (w_q.size() > 0) begin
               we = w_q.pop_front();
               check_eq("w_grant", 64'(grant), 64'(1 << cur_owner));
               check_eq("w_data", m_wdata, we.data);
               check_eq("w_strb", 64'(m_wstrb), 64'(we.strb));
               check_eq("w_last", 64'(m_wlast), 64'(we.last));
            end
         end
      end
   end

   // Slave model: AW always ready, W ready steady or toggling, one B per wlast.
   initial begin
      bit wl, bh;
      m_awready = 1'b1;
      m_wready  = 1'b1;
      m_bvalid  = 1'b0;
      m_bresp   = BRESP_OKAY;
      forever begin
         @(negedge clk);
         wl = m_wvalid && m_wready && m_wlast;
         bh = m_bvalid && m_bready;
         @(posedge clk);
         #1;
         if (axi_areset) begin
            m_bvalid = 1'b0;
         end else begin
            if (bh) m_bvalid = 1'b0;
            if (wl) begin
               m_bvalid = 1'b1;
               m_bresp  = bresp_cfg;
            end
         end
         m_wready = w_toggle ? ~m_wready : 1'b1;
      end
   end

   // kind: 0 = AW ready, 1 = W ready, 2 = B valid (checked on arrival).
   task automatic wait_ready(input int r, input int kind, output bit hs);
      int n = 0;
      hs = 1'b0;
      while (!hs && n < WAIT_MAX) begin
         @(negedge clk);
         case (kind)
            0:       hs = s_awready[r];
            1:       hs = s_wready[r];
            default: hs = s_bvalid[r];
         endcase
         if (hs && kind == 2) begin
            check_eq("b_onehot", 64'(s_bvalid), 64'(1 << r));
            check_eq("b_resp", 64'(s_bresp), 64'(bresp_cfg));
         end
         @(posedge clk);
         #1;
         n++;
      end
      check_eq($sformatf("hs_r%0d_k%0d", r, kind), 64'(hs), 64'd1);
   endtask

   // One complete requester-side burst; bad_beat >= 0 raises wlast early.
   task automatic run_req(input int r, input int id, input logic [7:0] len,
                          input int bad_beat);
      bit hs;
      s_awaddr[r*AW +: AW] = addr_of(r);
      s_awlen[r*8 +: 8]    = len;
      s_awsize[r*3 +: 3]   = 3'd3;
      s_awburst[r*2 +: 2]  = 2'b01;
      s_awvalid[r]         = 1'b1;
      raise_cyc[r]         = cyc;
      wait_ready(r, 0, hs);
      s_awvalid[r] = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         s_wdata[r*DW +: DW] = data_of(r, id, b);
         s_wstrb[r*8 +: 8]   = 8'hFF ^ 8'(b);
         s_wlast[r]          = (b == int'(len)) || (b == bad_beat);
         s_wvalid[r]         = 1'b1;
         w_q.push_back('{data_of(r, id, b), 8'hFF ^ 8'(b), b == int'(len)});
         wait_ready(r, 1, hs);
         if (!hs) break;
      end
      s_wvalid[r] = 1'b0;
      s_wlast[r]  = 1'b0;
      s_bready[r] = 1'b1;
      wait_ready(r, 2, hs);
      s_bready[r] = 1'b0;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hs;
      axi_areset = 1'b1;
      s_awvalid  = '0;
      s_awaddr   = '0;
      s_awlen    = '0;
      s_awsize   = '0;
      s_awburst  = '0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_wlast    = '0;
      s_wvalid   = '0;
      s_bready   = '0;

      // Reset state while both requesters already request
      s_awvalid = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_grant", 64'(grant), 64'd0);
      check_eq("rst_m_awvalid", 64'(m_awvalid), 64'd0);
      check_eq("rst_s_awready", 64'(s_awready), 64'd0);
      check_eq("rst_m_wvalid", 64'(m_wvalid), 64'd0);
      check_eq("rst_s_wready", 64'(s_wready), 64'd0);
      check_eq("rst_s_bvalid", 64'(s_bvalid), 64'd0);
      check_eq("rst_m_bready", 64'(m_bready), 64'd0);
      check_eq("rst_wlast_err", 64'(wlast_err), 64'd0);
      @(posedge clk);
      #1;

      // Both requesters at reset release: 0 then 1, then 0 then 1 again
      for (int round = 0; round < 2; round++) begin
         aw_q.push_back('{0, 8'd0});
         aw_q.push_back('{1, 8'd0});
         if (round == 0) axi_areset = 1'b0;
         fork
            run_req(0, 10 + round, 8'd0, -1);
            run_req(1, 20 + round, 8'd0, -1);
         join
      end
      check_eq("rr_grant_idle", 64'(grant), 64'd0);

      // Single requester, awlen=3, one-cycle arbitration latency
      chk_lat = 1'b1;
      aw_q.push_back('{0, 8'd3});
      run_req(0, 30, 8'd3, -1);
      chk_lat = 1'b0;
      check_eq("single_grant_idle", 64'(grant), 64'd0);
      check_eq("single_wq_empty", 64'(w_q.size()), 64'd0);

      // Toggling m_wready, awlen=7; idle requester 1 offers W and must be ignored
      bresp_cfg     = BRESP_SLVERR;
      s_wdata[DW +: DW] = 64'hDEAD_BEEF_DEAD_BEEF;
      s_wvalid[1]   = 1'b1;
      s1_wready_cnt = 0;
      w_hs_cnt      = 0;
      w_toggle      = 1'b1;
      aw_q.push_back('{0, 8'd7});
      run_req(0, 40, 8'd7, -1);
      w_toggle      = 1'b0;
      s_wvalid[1]   = 1'b0;
      bresp_cfg     = BRESP_OKAY;
      check_eq("toggle_beats", 64'(w_hs_cnt), 64'd8);
      check_eq("toggle_s1_wready", 64'(s1_wready_cnt), 64'd0);
      check_eq("pre_err_clear", 64'(wlast_err), 64'd0);

      // Early wlast on beat 2 of 4: sticky error, burst still runs 4 beats
      w_hs_cnt = 0;
      aw_q.push_back('{1, 8'd3});
      run_req(1, 50, 8'd3, 1);
      check_eq("err_set", 64'(wlast_err), 64'd1);
      check_eq("err_beats", 64'(w_hs_cnt), 64'd4);

      // 256-beat burst, no counter wrap
      w_hs_cnt = 0;
      aw_q.push_back('{0, 8'd255});
      run_req(0, 60, 8'd255, -1);
      check_eq("long_beats", 64'(w_hs_cnt), 64'd256);
      check_eq("long_wq_empty", 64'(w_q.size()), 64'd0);
      check_eq("err_sticky", 64'(wlast_err), 64'd1);

      // Reset pulse during the second beat of a burst
      aw_q.push_back('{0, 8'd3});
      s_awaddr[0 +: AW] = addr_of(0);
      s_awlen[0 +: 8]   = 8'd3;
      s_awsize[0 +: 3]  = 3'd3;
      s_awburst[0 +: 2] = 2'b01;
      s_awvalid[0]      = 1'b1;
      wait_ready(0, 0, hs);
      s_awvalid[0] = 1'b0;
      s_wdata[0 +: DW] = data_of(0, 70, 0);
      s_wstrb[0 +: 8]  = 8'hFF;
      s_wvalid[0]      = 1'b1;
      w_q.push_back('{data_of(0, 70, 0), 8'hFF, 1'b0});
      wait_ready(0, 1, hs);
      s_wdata[0 +: DW] = data_of(0, 70, 1);
      s_wstrb[0 +: 8]  = 8'hFE;
      #1;
      check_eq("pre_rst_wvalid", 64'(m_wvalid), 64'd1);
      axi_areset = 1'b1;
      #1;
      check_eq("mid_rst_grant", 64'(grant), 64'd0);
      check_eq("mid_rst_m_wvalid", 64'(m_wvalid), 64'd0);
      check_eq("mid_rst_s_wready", 64'(s_wready), 64'd0);
      check_eq("mid_rst_m_awvalid", 64'(m_awvalid), 64'd0);
      check_eq("mid_rst_m_bready", 64'(m_bready), 64'd0);
      check_eq("mid_rst_wlast_err", 64'(wlast_err), 64'd0);
      @(posedge clk);
      #1;
      s_wvalid[0] = 1'b0;
      axi_areset  = 1'b0;
      check_eq("mid_rst_wq_empty", 64'(w_q.size()), 64'd0);

      // After reset the pointer restarts: requester 0 wins over 1
      aw_q.push_back('{0, 8'd1});
      aw_q.push_back('{1, 8'd1});
      fork
         run_req(0, 80, 8'd1, -1);
         run_req(1, 81, 8'd1, -1);
      join
      check_eq("post_rst_aw_q_empty", 64'(aw_q.size()), 64'd0);
      check_eq("post_rst_grant_idle", 64'(grant), 64'd0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
